// File: rtl/demod_lock_ctrl.sv
// demod_lock_ctrl: acquisition/lock sequencer for the QPSK demodulator (clk_sam domain).
// Sequences IDLE -> ACQ (wide Costas gain) -> TRACK (narrow gain, Gardner released)
// -> LOCKED, and falls back to ACQ on repeated bad frames or header timeout.
// Optional statistics counters are built only when DEMOD_LOCK_STATS_EN is defined;
// otherwise frame_cnt_o/err_cnt_o are tied to zero.
module demod_lock_ctrl #(
  parameter int unsigned ERR_W       = 16,
  parameter int unsigned LOCK_TH     = 512,
  parameter int unsigned LOCK_CNT    = 1000,
  parameter int unsigned HDR_TIMEOUT = 4000,
  parameter int unsigned MISS_MAX    = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic signed [ERR_W-1:0] phase_err_i,
  input  logic                    sync_flag_i,
  input  logic                    header_flag_i,
  input  logic                    valid_flag_i,
  output logic                    loop_wide_o,
  output logic                    sync_rst_n_o,
  output logic                    locked_o,
  output logic [1:0]              state_o,
  output logic [CNT_W-1:0]        frame_cnt_o,
  output logic [CNT_W-1:0]        err_cnt_o
);

  localparam int unsigned RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned SYM_W  = $clog2(HDR_TIMEOUT + 1);
  localparam int unsigned MISS_W = $clog2(MISS_MAX + 1);

  localparam logic [ERR_W-1:0] ERR_MAX = {1'b0, {(ERR_W-1){1'b1}}};
  localparam logic [ERR_W-1:0] ERR_MIN = {1'b1, {(ERR_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACQ    = 2'd1,
    S_TRACK  = 2'd2,
    S_LOCKED = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
  logic [SYM_W-1:0]    sym_cnt_q, sym_cnt_d;
  logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic                loop_wide_q, loop_wide_d;
  logic                sync_rst_n_q, sync_rst_n_d;
  logic                locked_q, locked_d;

  logic [ERR_W-1:0]    abs_err;
  logic                in_lock;
  logic                tracking;
  logic                good_frame;
  logic                bad_frame;
  logic                miss_hit;
  logic                tmo_hit;

  // Magnitude of the phase error; the most negative code saturates to the positive max.
  always_comb begin
    abs_err = phase_err_i;
    if (phase_err_i == ERR_MIN) begin
      abs_err = ERR_MAX;
    end else if (phase_err_i[ERR_W-1]) begin
      abs_err = ERR_W'(-phase_err_i);
    end
    in_lock = (32'(abs_err) < LOCK_TH);
  end

  // Frame events in TRACK/LOCKED, resolved with priority valid > miss > timeout.
  always_comb begin
    tracking   = (state_q == S_TRACK) || (state_q == S_LOCKED);
    good_frame = enable_i && tracking && valid_flag_i;
    bad_frame  = enable_i && tracking && header_flag_i && !valid_flag_i;
    miss_hit   = bad_frame && ((32'(miss_cnt_q) + 32'd1) >= MISS_MAX);
    tmo_hit    = enable_i && tracking && !valid_flag_i && !miss_hit && sync_flag_i &&
                 ((32'(sym_cnt_q) + 32'd1) >= HDR_TIMEOUT);
  end

  // Next-state, working counters and registered output decode.
  always_comb begin
    state_d      = state_q;
    run_cnt_d    = run_cnt_q;
    sym_cnt_d    = sym_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    loop_wide_d  = 1'b1;
    sync_rst_n_d = 1'b0;
    locked_d     = 1'b0;

    if (!enable_i) begin
      state_d    = S_IDLE;
      run_cnt_d  = '0;
      sym_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d    = S_ACQ;
          run_cnt_d  = '0;
          sym_cnt_d  = '0;
          miss_cnt_d = '0;
        end
        S_ACQ: begin
          if (!in_lock) begin
            run_cnt_d = '0;
          end else if (32'(run_cnt_q) == (LOCK_CNT - 1)) begin
            state_d   = S_TRACK;
            run_cnt_d = '0;
          end else begin
            run_cnt_d = run_cnt_q + RUN_W'(1);
          end
        end
        S_TRACK, S_LOCKED: begin
          if (good_frame) begin
            state_d    = S_LOCKED;
            sym_cnt_d  = '0;
            miss_cnt_d = '0;
          end else if (miss_hit || tmo_hit) begin
            state_d    = S_ACQ;
            run_cnt_d  = '0;
            sym_cnt_d  = '0;
            miss_cnt_d = '0;
          end else begin
            sym_cnt_d  = sym_cnt_q + SYM_W'(sync_flag_i);
            miss_cnt_d = miss_cnt_q + MISS_W'(bad_frame);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if ((state_d == S_TRACK) || (state_d == S_LOCKED)) begin
      loop_wide_d  = 1'b0;
      sync_rst_n_d = 1'b1;
    end
    locked_d = (state_d == S_LOCKED);
  end

  // State, working counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      run_cnt_q    <= '0;
      sym_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      loop_wide_q  <= 1'b1;
      sync_rst_n_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      sym_cnt_q    <= sym_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      loop_wide_q  <= loop_wide_d;
      sync_rst_n_q <= sync_rst_n_d;
      locked_q     <= locked_d;
    end
  end

  assign loop_wide_o  = loop_wide_q;
  assign sync_rst_n_o = sync_rst_n_q;
  assign locked_o     = locked_q;
  assign state_o      = state_q;

`ifdef DEMOD_LOCK_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [1:0]       err_inc;

  // Saturating statistics; a header miss and a timeout in the same cycle both count.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_inc     = 2'(bad_frame) + 2'(tmo_hit);
    if (good_frame && (frame_cnt_q != CNT_MAX)) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end
    if (err_cnt_q > (CNT_MAX - CNT_W'(err_inc))) begin
      err_cnt_d = CNT_MAX;
    end else begin
      err_cnt_d = err_cnt_q + CNT_W'(err_inc);
    end
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign err_cnt_o   = err_cnt_q;
`else
  assign frame_cnt_o = '0;
  assign err_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_demod_lock_ctrl.sv
// Scoreboard bench for demod_lock_ctrl: the driver pushes each expected output
// vector together with the cycle it must appear in; the monitor pops and compares
// whenever the observed output vector changes.
module tb_demod_lock_ctrl;

  localparam int unsigned ERR_W       = 16;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned LOCK_CNT    = 1000;
  localparam int unsigned HDR_TIMEOUT = 4000;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACQ    = 2'd1;
  localparam logic [1:0] S_TRACK  = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;

  typedef struct packed {
    logic [1:0]       st;
    logic             lw;
    logic             sr;
    logic             lk;
    logic [CNT_W-1:0] fc;
    logic [CNT_W-1:0] ec;
  } vec_t;

  typedef struct {
    vec_t        v;
    int unsigned stamp;
    string       tag;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    enable = 1'b0;
  logic signed [ERR_W-1:0] phase_err = '0;
  logic                    sync_flag = 1'b0;
  logic                    header_flag = 1'b0;
  logic                    valid_flag = 1'b0;
  logic                    loop_wide;
  logic                    sync_rst_n;
  logic                    locked;
  logic [1:0]              state;
  logic [CNT_W-1:0]        frame_cnt;
  logic [CNT_W-1:0]        err_cnt;

  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned exp_fc = 0;
  int unsigned exp_ec = 0;
  exp_t        sbq[$];
  vec_t        last_exp;
  bit          have_exp = 1'b0;

  demod_lock_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable),
    .phase_err_i  (phase_err),
    .sync_flag_i  (sync_flag),
    .header_flag_i(header_flag),
    .valid_flag_i (valid_flag),
    .loop_wide_o  (loop_wide),
    .sync_rst_n_o (sync_rst_n),
    .locked_o     (locked),
    .state_o      (state),
    .frame_cnt_o  (frame_cnt),
    .err_cnt_o    (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Push an expected output vector (only when it differs from the previous one).
  task automatic expect_at(input int unsigned stamp, input logic [1:0] st, input string tag);
    vec_t v;
    exp_t e;
    v.st = st;
    v.lw = (st == S_IDLE) || (st == S_ACQ);
    v.sr = (st == S_TRACK) || (st == S_LOCKED);
    v.lk = (st == S_LOCKED);
`ifdef DEMOD_LOCK_STATS_EN
    v.fc = CNT_W'(exp_fc);
    v.ec = CNT_W'(exp_ec);
`else
    v.fc = '0;
    v.ec = '0;
`endif
    if (!have_exp || (v != last_exp)) begin
      e.v = v;
      e.stamp = stamp;
      e.tag = tag;
      sbq.push_back(e);
    end
    last_exp = v;
    have_exp = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic good_frame(input string tag);
    header_flag = 1'b1;
    valid_flag = 1'b1;
    exp_fc++;
    expect_at(cyc + 1, S_LOCKED, tag);
    tick();
    header_flag = 1'b0;
    valid_flag = 1'b0;
    tick();
  endtask

  task automatic bad_frame(input logic [1:0] st_after, input string tag);
    header_flag = 1'b1;
    exp_ec++;
    expect_at(cyc + 1, st_after, tag);
    tick();
    header_flag = 1'b0;
    tick();
  endtask

  // 4000 sync strobes with gaps; optionally a valid frame on the last strobe cycle.
  task automatic strobe_run(input bit valid_on_last, input string tag);
    int unsigned nstr;
    nstr = 0;
    while (nstr < HDR_TIMEOUT) begin
      sync_flag = ((cyc % 7) != 0);
      if (sync_flag) begin
        nstr++;
        if (nstr == HDR_TIMEOUT) begin
          if (valid_on_last) begin
            valid_flag = 1'b1;
            exp_fc++;
            expect_at(cyc + 1, S_LOCKED, tag);
          end else begin
            exp_ec++;
            expect_at(cyc + 1, S_ACQ, tag);
          end
        end
      end
      tick();
    end
    sync_flag = 1'b0;
    valid_flag = 1'b0;
  endtask

  // Monitor: compare on the first sample and on every change of the output vector.
  initial begin : monitor
    vec_t prev;
    vec_t cur;
    exp_t e;
    bit   first;
    first = 1'b1;
    prev = '0;
    @(negedge clk);
    forever begin
      #1;
      cur.st = state;
      cur.lw = loop_wide;
      cur.sr = sync_rst_n;
      cur.lk = locked;
      cur.fc = frame_cnt;
      cur.ec = err_cnt;
      if (first || (cur !== prev)) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change: got st=%0d lw=%0b sr=%0b lk=%0b fc=%0d ec=%0d @cyc %0d, required no change",
                   cur.st, cur.lw, cur.sr, cur.lk, cur.fc, cur.ec, cyc);
        end else begin
          e = sbq.pop_front();
          if ((cur !== e.v) || (cyc != e.stamp)) begin
            n_bad++;
            $display("FAIL %s: got st=%0d lw=%0b sr=%0b lk=%0b fc=%0d ec=%0d @cyc %0d, required st=%0d lw=%0b sr=%0b lk=%0b fc=%0d ec=%0d @cyc %0d",
                     e.tag, cur.st, cur.lw, cur.sr, cur.lk, cur.fc, cur.ec, cyc,
                     e.v.st, e.v.lw, e.v.sr, e.v.lk, e.v.fc, e.v.ec, e.stamp);
          end
        end
      end
      prev = cur;
      first = 1'b0;
      @(negedge clk or negedge rst_n);
    end
  end

  // Driver: directed scenario with hand-derived cycle stamps.
  initial begin : driver
    int unsigned c;
    int unsigned s;

    expect_at(1, S_IDLE, "reset_state");
    tick();
    tick();

    // Release reset with enable: ACQ next cycle, TRACK LOCK_CNT cycles after entering ACQ.
    rst_n = 1'b1;
    enable = 1'b1;
    c = cyc;
    expect_at(c + 1, S_ACQ, "idle_to_acq");
    expect_at(c + 1 + LOCK_CNT, S_TRACK, "acq_to_track");
    repeat (LOCK_CNT + 1) tick();

    good_frame("track_to_locked");

    // Three header-only pulses: third one forces ACQ.
    bad_frame(S_LOCKED, "miss1");
    bad_frame(S_LOCKED, "miss2");
    bad_frame(S_ACQ, "miss3_to_acq");
    s = cyc - 1;

    // Out-of-lock samples at the would-be final sample restart the run each time.
    expect_at(s + 4 * LOCK_CNT, S_TRACK, "acq_glitch_to_track");
    while (cyc < s + 4 * LOCK_CNT) begin
      c = cyc + 1;
      if (c == s + LOCK_CNT)            phase_err = 16'sd600;
      else if (c == s + 2 * LOCK_CNT)   phase_err = 16'sh8000;
      else if (c == s + 3 * LOCK_CNT)   phase_err = 16'sd512;
      else if (c[0])                    phase_err = 16'sd511;
      else                              phase_err = -16'sd511;
      tick();
    end
    phase_err = '0;

    good_frame("track_to_locked2");

    // Header timeout in LOCKED.
    strobe_run(1'b0, "timeout_to_acq");
    s = cyc;
    expect_at(s + LOCK_CNT, S_TRACK, "reacq_to_track");
    repeat (LOCK_CNT) tick();
    good_frame("track_to_locked3");

    // A valid frame clears the miss count.
    bad_frame(S_LOCKED, "miss_a1");
    bad_frame(S_LOCKED, "miss_a2");
    good_frame("valid_clears_miss");
    bad_frame(S_LOCKED, "miss_b1");
    bad_frame(S_LOCKED, "miss_b2");
    good_frame("valid_clears_miss2");

    // Valid frame on the timeout strobe wins.
    strobe_run(1'b1, "valid_beats_timeout");

    // Disable to IDLE, stats retained; re-enable to ACQ.
    enable = 1'b0;
    expect_at(cyc + 1, S_IDLE, "disable_to_idle");
    tick();
    tick();
    enable = 1'b1;
    expect_at(cyc + 1, S_ACQ, "reenable_to_acq");
    repeat (500) tick();

    // Asynchronous reset mid-ACQ takes effect without a clock edge.
    exp_fc = 0;
    exp_ec = 0;
    expect_at(cyc, S_IDLE, "async_reset");
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();

    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d expected entries left, required 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
